// File: rtl/torus_pkg.sv
// Shared types and constants for the torus injection queue.
// Optional feature macro: TORUS_INJ_STALL_CNT_EN (stall counter / stalled flag).
package torus_pkg;

    localparam int X_W          = 2;   // destination x-address width
    localparam int Y_W          = 2;   // destination y-address width
    localparam int D_W          = 32;  // payload width
    localparam int DEPTH_DEF    = 4;   // default FIFO entries (power of 2, >= 2)
    localparam int CNT_W_DEF    = 16;  // default sent/received counter width
    localparam int STALL_THRESH = 8;   // consecutive unacked cycles before "stalled"

    // One queued message as it travels to the switch inject port.
    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [D_W-1:0] data;
    } torus_msg_t;

    // Occupancy view of the queue, exported for debug.
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_e;

    // Pointer width: index bits plus one wrap bit that separates full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PTR_W = ptr_w(DEPTH_DEF);

endpackage

// File: rtl/torus_inject_queue_if.sv
// PE / switch side signal bundle of the torus injection queue.
// Optional feature macro: TORUS_INJ_STALL_CNT_EN adds stall_cnt and stalled.
//
// Handshakes: a PE push happens on a clock edge where pe_v && pe_ready;
// an inject transfer happens on an edge where i_v && i_ack. pe_ready and
// i_v never depend combinationally on pe_v / i_ack of the same cycle,
// and the head fields stay stable while i_v is high and i_ack is low.
interface torus_inject_queue_if
    import torus_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             pe_v;
    logic [X_W-1:0]   pe_x;
    logic [Y_W-1:0]   pe_y;
    logic [D_W-1:0]   pe_data;
    logic             pe_ready;
    logic             flush;
    logic             i_v;
    logic [X_W-1:0]   i_x;
    logic [Y_W-1:0]   i_y;
    logic [D_W-1:0]   i_data;
    logic             i_ack;
    logic             ej_v;
    logic [D_W-1:0]   ej_data;
    logic             rx_v;
    logic [D_W-1:0]   rx_data;
    logic [CNT_W-1:0] sent_cnt;
    logic [CNT_W-1:0] recv_cnt;
    logic             empty;
    logic             full;
    occ_state_e       dbg_state;
`ifdef TORUS_INJ_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic             stalled;
`endif

    // Queue side.
    modport slave (
        input  pe_v, pe_x, pe_y, pe_data, flush, i_ack, ej_v, ej_data,
        output pe_ready, i_v, i_x, i_y, i_data, rx_v, rx_data,
        output sent_cnt, recv_cnt, empty, full, dbg_state
`ifdef TORUS_INJ_STALL_CNT_EN
        , output stall_cnt, stalled
`endif
    );

    // PE / switch side.
    modport master (
        output pe_v, pe_x, pe_y, pe_data, flush, i_ack, ej_v, ej_data,
        input  pe_ready, i_v, i_x, i_y, i_data, rx_v, rx_data,
        input  sent_cnt, recv_cnt, empty, full, dbg_state
`ifdef TORUS_INJ_STALL_CNT_EN
        , input stall_cnt, stalled
`endif
    );

endinterface

// File: rtl/torus_msg_fifo.sv
// Circular message FIFO: storage array, read/write pointers, full/empty.
// Callers gate wr_en with !full and rd_en with !empty.
module torus_msg_fifo
    import torus_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    localparam int PW   = ptr_w(DEPTH),
    localparam int AW   = PW - 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  torus_msg_t    wr_msg,
    input  logic          rd_en,
    input  logic          flush,
    output torus_msg_t    rd_msg,
    output logic          empty,
    output logic          full,
    output logic [PW-1:0] level
);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    torus_msg_t    mem_q [DEPTH];

    // Pointer advance; flush collapses the read pointer onto the write pointer.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) wptr_d = wptr_q + PW'(1);
        if (rd_en) rptr_d = rptr_q + PW'(1);
        if (flush) rptr_d = wptr_d;
    end

    // Pointer registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wr_msg;
    end

    assign rd_msg = mem_q[rptr_q[AW-1:0]];
    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level  = wptr_q - rptr_q;

endmodule

// File: rtl/torus_inject_queue.sv
// Per-node injection/ejection buffer between a PE and the torus switch PE port.
// Queues PE messages, presents the head to the switch until acked, registers
// locally delivered messages and counts sent/received traffic.
// Optional feature macro: TORUS_INJ_STALL_CNT_EN (stall_cnt / stalled outputs).
module torus_inject_queue
    import torus_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    torus_inject_queue_if.slave  bus
);

    localparam int PW = ptr_w(DEPTH);

    logic          fifo_empty, fifo_full;
    logic          pe_ready_w, push, pop;
    torus_msg_t    wr_msg, head;
    logic [PW-1:0] level, level_nx;

    logic             rx_v_q, rx_v_d;
    logic [D_W-1:0]   rx_data_q, rx_data_d;
    logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
    logic [CNT_W-1:0] recv_cnt_q, recv_cnt_d;
    occ_state_e       state_q, state_d;

    // No bypass: a full queue refuses a push even when the head leaves this cycle.
    assign pe_ready_w = !fifo_full && !bus.flush;
    assign push       = bus.pe_v && pe_ready_w;
    assign pop        = !fifo_empty && bus.i_ack;
    assign wr_msg     = '{x: bus.pe_x, y: bus.pe_y, data: bus.pe_data};

    torus_msg_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (push),
        .wr_msg (wr_msg),
        .rd_en  (pop),
        .flush  (bus.flush),
        .rd_msg (head),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .level  (level)
    );

    assign bus.pe_ready = pe_ready_w;
    assign bus.i_v      = !fifo_empty;
    assign bus.i_x      = head.x;
    assign bus.i_y      = head.y;
    assign bus.i_data   = head.data;
    assign bus.empty    = fifo_empty;
    assign bus.full     = fifo_full;
    assign bus.rx_v     = rx_v_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.sent_cnt = sent_cnt_q;
    assign bus.recv_cnt = recv_cnt_q;
    assign bus.dbg_state = state_q;

    // Counters and the ejection capture register; a head popped in a flush cycle still counts.
    always_comb begin
        sent_cnt_d = sent_cnt_q;
        recv_cnt_d = recv_cnt_q;
        rx_v_d     = bus.ej_v;
        rx_data_d  = rx_data_q;
        if (pop) sent_cnt_d = sent_cnt_q + CNT_W'(1);
        if (bus.ej_v) begin
            rx_data_d  = bus.ej_data;
            recv_cnt_d = recv_cnt_q + CNT_W'(1);
        end
    end

    // Counter / ejection registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sent_cnt_q <= '0;
            recv_cnt_q <= '0;
            rx_v_q     <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            sent_cnt_q <= sent_cnt_d;
            recv_cnt_q <= recv_cnt_d;
            rx_v_q     <= rx_v_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // Occupancy state: next level from push/pop, flush forces EMPTY.
    always_comb begin
        level_nx = level;
        state_d  = state_q;
        if (push) level_nx = level_nx + PW'(1);
        if (pop)  level_nx = level_nx - PW'(1);
        if (bus.flush) level_nx = '0;
        if (level_nx == '0)
            state_d = OCC_EMPTY;
        else if (level_nx == PW'(DEPTH))
            state_d = OCC_FULL;
        else
            state_d = OCC_PARTIAL;
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= OCC_EMPTY;
        else      state_q <= state_d;
    end

`ifdef TORUS_INJ_STALL_CNT_EN
    localparam int RUN_W = $clog2(STALL_THRESH + 1);

    logic             waiting;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             stalled_q, stalled_d;

    assign waiting = !fifo_empty && !bus.i_ack;

    // Saturating stall count plus a run length of consecutive unacked cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        run_d       = '0;
        if (waiting && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (waiting) run_d = (run_q == RUN_W'(STALL_THRESH)) ? run_q : run_q + RUN_W'(1);
        stalled_d = (run_d == RUN_W'(STALL_THRESH));
    end

    // Stall registers; flush deliberately leaves stall_cnt alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            run_q       <= '0;
            stalled_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            run_q       <= run_d;
            stalled_q   <= stalled_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.stalled   = stalled_q;
`endif

endmodule

// File: tb/tb_torus_inject_queue.sv
// Directed bench for torus_inject_queue: a vector table for single-cycle
// behaviour plus hand-written sequences for push/pop overlap, flush,
// asynchronous reset and the optional stall counter.
module tb_torus_inject_queue;
    import torus_pkg::*;

    localparam int MW = X_W + Y_W + D_W;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_sent;

    logic [MW-1:0] exp_q[$];

    torus_inject_queue_if #(.CNT_W(16)) bus ();

    torus_inject_queue #(.DEPTH(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic          pv;
        logic [MW-1:0] pm;
        logic          ack;
        logic          ejv;
        logic [31:0]   ejd;
        logic          rdy;
        logic          iv;
        logic [MW-1:0] hm;
        logic          emp;
        logic          full;
        logic [15:0]   sent;
        logic [15:0]   recv;
        logic          rxv;
        logic [31:0]   rxd;
        logic [1:0]    st;
    } vec_t;

    vec_t vq[$];

    function automatic logic [MW-1:0] m(input logic [1:0] x, input logic [1:0] y, input logic [31:0] d);
        return {x, y, d};
    endfunction

    task automatic add(input logic pv, input logic [MW-1:0] pm, input logic ack,
                       input logic ejv, input logic [31:0] ejd, input logic rdy,
                       input logic iv, input logic [MW-1:0] hm, input logic emp,
                       input logic full, input logic [15:0] sent, input logic [15:0] recv,
                       input logic rxv, input logic [31:0] rxd, input occ_state_e st);
        vec_t v;
        v.pv = pv; v.pm = pm; v.ack = ack; v.ejv = ejv; v.ejd = ejd;
        v.rdy = rdy; v.iv = iv; v.hm = hm; v.emp = emp; v.full = full;
        v.sent = sent; v.recv = recv; v.rxv = rxv; v.rxd = rxd; v.st = st;
        vq.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pe(input logic v, input logic [MW-1:0] msg);
        bus.pe_v    = v;
        bus.pe_x    = msg[MW-1 -: X_W];
        bus.pe_y    = msg[D_W+Y_W-1 -: Y_W];
        bus.pe_data = msg[D_W-1:0];
    endtask

    function automatic logic [MW-1:0] head_msg();
        return {bus.i_x, bus.i_y, bus.i_data};
    endfunction

    task automatic idle_inputs();
        drive_pe(1'b0, '0);
        bus.flush   = 1'b0;
        bus.i_ack   = 1'b0;
        bus.ej_v    = 1'b0;
        bus.ej_data = '0;
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        logic [MW-1:0] ma;
        logic [MW-1:0] nm;
        rst = 1'b0;
        idle_inputs();
        ma = m(2'd1, 2'd2, 32'hA5A5_0001);

        // Table: pv, pm, ack, ejv, ejd | rdy, iv, head, empty, full, sent, recv, rx_v, rx_data, state
        add(1, ma, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, OCC_EMPTY);
        for (int k = 0; k < 5; k++)
            add(0, 0, 0, 0, 0, 1, 1, ma, 0, 0, 0, 0, 0, 0, OCC_PARTIAL);
        add(0, 0, 1, 0, 0, 1, 1, ma, 0, 0, 0, 0, 0, 0, OCC_PARTIAL);
        add(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, OCC_EMPTY);
        // Fill to full, refuse two extra pushes (one with a same-cycle pop), drain in order.
        add(1, m(0, 0, 32'h10), 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, OCC_EMPTY);
        add(1, m(1, 1, 32'h11), 0, 0, 0, 1, 1, m(0, 0, 32'h10), 0, 0, 1, 0, 0, 0, OCC_PARTIAL);
        add(1, m(2, 2, 32'h12), 0, 0, 0, 1, 1, m(0, 0, 32'h10), 0, 0, 1, 0, 0, 0, OCC_PARTIAL);
        add(1, m(3, 3, 32'h13), 0, 0, 0, 1, 1, m(0, 0, 32'h10), 0, 0, 1, 0, 0, 0, OCC_PARTIAL);
        add(1, m(0, 1, 32'h14), 0, 0, 0, 0, 1, m(0, 0, 32'h10), 0, 1, 1, 0, 0, 0, OCC_FULL);
        add(1, m(3, 0, 32'h99), 1, 0, 0, 0, 1, m(0, 0, 32'h10), 0, 1, 1, 0, 0, 0, OCC_FULL);
        add(0, 0, 1, 0, 0, 1, 1, m(1, 1, 32'h11), 0, 0, 2, 0, 0, 0, OCC_PARTIAL);
        add(0, 0, 1, 0, 0, 1, 1, m(2, 2, 32'h12), 0, 0, 3, 0, 0, 0, OCC_PARTIAL);
        add(0, 0, 1, 0, 0, 1, 1, m(3, 3, 32'h13), 0, 0, 4, 0, 0, 0, OCC_PARTIAL);
        add(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 5, 0, 0, 0, OCC_EMPTY);
        // Wrapped pointers: four more pushes and drains.
        add(1, m(1, 0, 32'h20), 0, 0, 0, 1, 0, 0, 1, 0, 5, 0, 0, 0, OCC_EMPTY);
        add(1, m(1, 1, 32'h21), 0, 0, 0, 1, 1, m(1, 0, 32'h20), 0, 0, 5, 0, 0, 0, OCC_PARTIAL);
        add(1, m(1, 2, 32'h22), 0, 0, 0, 1, 1, m(1, 0, 32'h20), 0, 0, 5, 0, 0, 0, OCC_PARTIAL);
        add(1, m(1, 3, 32'h23), 0, 0, 0, 1, 1, m(1, 0, 32'h20), 0, 0, 5, 0, 0, 0, OCC_PARTIAL);
        add(0, 0, 0, 0, 0, 0, 1, m(1, 0, 32'h20), 0, 1, 5, 0, 0, 0, OCC_FULL);
        add(0, 0, 1, 0, 0, 0, 1, m(1, 0, 32'h20), 0, 1, 5, 0, 0, 0, OCC_FULL);
        add(0, 0, 1, 0, 0, 1, 1, m(1, 1, 32'h21), 0, 0, 6, 0, 0, 0, OCC_PARTIAL);
        add(0, 0, 1, 0, 0, 1, 1, m(1, 2, 32'h22), 0, 0, 7, 0, 0, 0, OCC_PARTIAL);
        add(0, 0, 1, 0, 0, 1, 1, m(1, 3, 32'h23), 0, 0, 8, 0, 0, 0, OCC_PARTIAL);
        add(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 9, 0, 0, 0, OCC_EMPTY);
        // Ejection capture.
        add(0, 0, 0, 1, 32'h1, 1, 0, 0, 1, 0, 9, 0, 0, 32'h0, OCC_EMPTY);
        add(0, 0, 0, 1, 32'h2, 1, 0, 0, 1, 0, 9, 1, 1, 32'h1, OCC_EMPTY);
        add(0, 0, 0, 0, 32'hDEAD_BEEF, 1, 0, 0, 1, 0, 9, 2, 1, 32'h2, OCC_EMPTY);
        add(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 9, 2, 0, 32'h2, OCC_EMPTY);

        // Reset state, held in reset.
        #12;
        chk("reset i_v", bus.i_v, 0);
        chk("reset empty", bus.empty, 1);
        chk("reset full", bus.full, 0);
        chk("reset pe_ready", bus.pe_ready, 1);
        rst = 1'b1;
        next_cycle();

        // Apply the table.
        for (int i = 0; i < vq.size(); i++) begin
            drive_pe(vq[i].pv, vq[i].pm);
            bus.i_ack   = vq[i].ack;
            bus.ej_v    = vq[i].ejv;
            bus.ej_data = vq[i].ejd;
            @(negedge clk);
            chk($sformatf("v%0d pe_ready", i), bus.pe_ready, vq[i].rdy);
            chk($sformatf("v%0d i_v", i), bus.i_v, vq[i].iv);
            if (vq[i].iv)
                chk($sformatf("v%0d head", i), head_msg(), vq[i].hm);
            chk($sformatf("v%0d empty", i), bus.empty, vq[i].emp);
            chk($sformatf("v%0d full", i), bus.full, vq[i].full);
            chk($sformatf("v%0d sent_cnt", i), bus.sent_cnt, vq[i].sent);
            chk($sformatf("v%0d recv_cnt", i), bus.recv_cnt, vq[i].recv);
            chk($sformatf("v%0d rx_v", i), bus.rx_v, vq[i].rxv);
            chk($sformatf("v%0d rx_data", i), bus.rx_data, vq[i].rxd);
            chk($sformatf("v%0d state", i), bus.dbg_state, vq[i].st);
            next_cycle();
        end
        idle_inputs();
        exp_sent = 9;

        // Simultaneous push and pop with two entries queued.
        for (int k = 0; k < 2; k++) begin
            nm = m(2'(k), 2'd3, 32'h30 + k);
            drive_pe(1'b1, nm);
            exp_q.push_back(nm);
            next_cycle();
        end
        for (int k = 0; k < 6; k++) begin
            nm = m(2'(k), 2'(k + 1), 32'h100 + k);
            drive_pe(1'b1, nm);
            bus.i_ack = 1'b1;
            @(negedge clk);
            chk($sformatf("ovl%0d head", k), head_msg(), exp_q[0]);
            chk($sformatf("ovl%0d pe_ready", k), bus.pe_ready, 1);
            chk($sformatf("ovl%0d state", k), bus.dbg_state, OCC_PARTIAL);
            next_cycle();
            void'(exp_q.pop_front());
            exp_q.push_back(nm);
            exp_sent++;
        end
        drive_pe(1'b0, '0);
        chk("ovl sent_cnt", bus.sent_cnt, 16'(exp_sent));
        for (int k = 0; k < 2; k++) begin
            bus.i_ack = 1'b1;
            @(negedge clk);
            chk($sformatf("ovl drain%0d head", k), head_msg(), exp_q[0]);
            next_cycle();
            void'(exp_q.pop_front());
            exp_sent++;
        end
        bus.i_ack = 1'b0;
        @(negedge clk);
        chk("ovl drained empty", bus.empty, 1);
        chk("ovl drained sent_cnt", bus.sent_cnt, 16'(exp_sent));
        next_cycle();

        // Flush together with an ack and an offered push, three queued.
        for (int k = 0; k < 3; k++) begin
            nm = m(2'd2, 2'(k + 1), 32'h40 + k);
            drive_pe(1'b1, nm);
            exp_q.push_back(nm);
            next_cycle();
        end
        drive_pe(1'b1, m(2'd3, 2'd3, 32'h77));
        bus.flush = 1'b1;
        bus.i_ack = 1'b1;
        @(negedge clk);
        chk("flush pe_ready", bus.pe_ready, 0);
        chk("flush head", head_msg(), exp_q[0]);
        next_cycle();
        exp_q.delete();
        exp_sent++;
        idle_inputs();
        chk("flush empty", bus.empty, 1);
        chk("flush i_v", bus.i_v, 0);
        chk("flush sent_cnt", bus.sent_cnt, 16'(exp_sent));
        chk("flush state", bus.dbg_state, OCC_EMPTY);
        drive_pe(1'b1, m(2'd0, 2'd2, 32'h50));
        next_cycle();
        drive_pe(1'b0, '0);
        chk("post-flush head", head_msg(), m(2'd0, 2'd2, 32'h50));
        bus.i_ack = 1'b1;
        next_cycle();
        bus.i_ack = 1'b0;
        exp_sent++;
        chk("post-flush sent_cnt", bus.sent_cnt, 16'(exp_sent));
        chk("post-flush empty", bus.empty, 1);

        // Asynchronous reset with two entries queued.
        for (int k = 0; k < 2; k++) begin
            drive_pe(1'b1, m(2'd1, 2'(k), 32'h60 + k));
            next_cycle();
        end
        drive_pe(1'b0, '0);
        chk("pre-reset i_v", bus.i_v, 1);
        chk("pre-reset recv_cnt", bus.recv_cnt, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("async i_v", bus.i_v, 0);
        chk("async sent_cnt", bus.sent_cnt, 0);
        chk("async recv_cnt", bus.recv_cnt, 0);
        chk("async rx_data", bus.rx_data, 0);
        chk("async empty", bus.empty, 1);
        chk("async pe_ready", bus.pe_ready, 1);
        chk("async state", bus.dbg_state, OCC_EMPTY);
        next_cycle();
        #1;
        rst = 1'b1;
        next_cycle();

`ifdef TORUS_INJ_STALL_CNT_EN
        // Ten unacked cycles, then an ack.
        drive_pe(1'b1, m(2'd1, 2'd1, 32'h70));
        next_cycle();
        drive_pe(1'b0, '0);
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            if (k == 7) chk("stalled after 7", bus.stalled, 0);
            if (k == 8) chk("stalled after 8", bus.stalled, 1);
        end
        chk("stall_cnt 10", bus.stall_cnt, 10);
        chk("stalled 10", bus.stalled, 1);
        bus.i_ack = 1'b1;
        next_cycle();
        bus.i_ack = 1'b0;
        chk("stalled cleared", bus.stalled, 0);
        chk("stall_cnt held", bus.stall_cnt, 10);
        chk("stall empty", bus.empty, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/torus_inject_queue.md
Name: torus_inject_queue

Overview:
- Per-node injection/ejection buffer between a processing element (PE) and the PE port of the 2-D torus switch.
- Queues PE messages in a circular FIFO and presents the head on the switch inject port (i_v/i_x/i_y/i_data). The head is held stable until the switch returns i_ack.
- Captures messages the switch ejects locally (o_v with s_out data) and keeps sent/received counters for completion detection.

Parameters:
- X_W, 2, destination x-address width
- Y_W, 2, destination y-address width
- D_W, 32, payload width
- DEPTH, 4, FIFO entries; power of 2, >= 2
- CNT_W, 16, width of the sent and received counters

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low (asserted when 0)
- pe_v  in  1  PE push request
- pe_x  in  X_W  PE message destination x
- pe_y  in  Y_W  PE message destination y
- pe_data  in  D_W  PE message payload
- pe_ready  out  1  queue can accept a push this cycle
- flush  in  1  discard all queued messages
- i_v  out  1  switch inject valid
- i_x  out  X_W  switch inject destination x
- i_y  out  Y_W  switch inject destination y
- i_data  out  D_W  switch inject payload
- i_ack  in  1  switch accepted the inject message this cycle (combinational from the switch)
- ej_v  in  1  switch local-delivery valid (the switch o_v)
- ej_data  in  D_W  switch delivered payload (the switch s_out_data)
- rx_v  out  1  registered delivered-message valid
- rx_data  out  D_W  registered delivered payload
- sent_cnt  out  CNT_W  messages accepted by the switch
- recv_cnt  out  CNT_W  messages delivered to this node
- empty  out  1  FIFO holds no entries
- full  out  1  FIFO holds DEPTH entries

Behaviour:
- Reset (rst=0, asynchronous): pointers, count, rx_v, rx_data, sent_cnt and recv_cnt all go to 0. Consequently empty=1, full=0, i_v=0, pe_ready=1. The FIFO storage array is not reset.
- Storage: circular buffer of DEPTH entries, each {x,y,data}. Read and write pointers are $clog2(DEPTH)+1 bits wide; the extra MSB separates full from empty.
- full is asserted when the pointers differ only in the MSB; empty when the pointers are equal.
- pe_ready = !full && !flush. There is no bypass: a push into a full FIFO is refused even if a pop happens in the same cycle.
- Push: when pe_v && pe_ready, the message is written at the write pointer and the write pointer increments (wrapping via the MSB).
- Inject port: i_v = !empty. i_x, i_y and i_data are read combinationally from the head entry.
  - Latency: a message pushed at edge N is visible on the inject port in cycle N+1.
- Pop: when i_v && i_ack, the read pointer increments and sent_cnt increments.
  - i_ack while i_v=0 is ignored; no state changes.
- Simultaneous push and pop (not full, not empty): both happen; occupancy is unchanged.
- flush:
  - If i_v && i_ack in the flush cycle, that head counts as sent (sent_cnt increments).
  - The read pointer is then set equal to the write pointer; no push is accepted that cycle.
  - The FIFO reads empty from the next cycle.
- Ejection: on each edge, rx_v <= ej_v. When ej_v=1, rx_data <= ej_data and recv_cnt increments. When ej_v=0, rx_data holds.
- Counters wrap modulo 2^CNT_W.
- Reset asserted mid-transfer: the queue is cleared and i_v drops immediately (asynchronously). No ack is owed.
- Implicit state machine on occupancy: EMPTY -> PARTIAL -> FULL.
  - Transitions come only from push, pop and flush; flush goes to EMPTY from any state.
  - DEPTH=2 passes through PARTIAL with a single entry.

Optional Feature:
- Macro: TORUS_INJ_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [CNT_W-1:0]. It increments each cycle with i_v && !i_ack, saturates at all-ones, and resets to 0 on rst.
  - flush does not clear stall_cnt.
  - Adds output stalled, a registered flag that is 1 after 8 consecutive unacked cycles and clears on the next ack.
- Undefined: neither port exists and no stall logic is built.

Decomposition:
- Shared package torus_pkg holds:
  - typedef torus_msg_t, a packed struct {x, y, data}, parameterised through package localparams that match X_W/Y_W/D_W;
  - localparam PTR_W function of DEPTH;
  - the stall threshold constant (8).
- One sub-module, torus_msg_fifo: the storage array, the pointers and full/empty. The top keeps the handshake, flush, counters and ejection register.

Test Plan:
- Reset, then push {x=1,y=2,data=32'hA5A5_0001} with i_ack held 0 for 5 cycles -> i_v=1 and fields stable from cycle 1 through the ack cycle; the ack pops the entry; sent_cnt=1; empty=1 next cycle.
- Push 4 messages with i_ack=0 -> full=1, pe_ready=0, a 5th push is refused; ack all 4 -> they leave in FIFO order; sent_cnt=4; the wrap-around pointers then take a further 4 pushes correctly.
- With 2 queued, push and ack in the same cycle for 6 cycles -> occupancy stays 2; order is preserved; sent_cnt=6.
- With 3 queued, assert flush together with i_ack -> sent_cnt increments by 1; empty=1 next cycle; a push offered in the flush cycle is dropped.
- ej_v pulses with data 32'h1, then 32'h2 -> rx_v/rx_data follow one cycle later; recv_cnt=2; rx_data holds 32'h2 afterwards.
- Drop rst mid-cycle while 2 entries are queued and i_v=1 -> i_v=0 and counters=0 without waiting for a clock edge. With TORUS_INJ_STALL_CNT_EN defined, 10 unacked cycles -> stall_cnt=10 and stalled=1; the next ack clears stalled.
